// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// State encoding, access size codes and the fixed fetch byte strobe.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] FETCH_SEL = 4'b1111;

endpackage

// File: rtl/arb_perf_counters.sv
// Grant and wait-cycle counters for the memory port arbiter.
// Only instantiated when ARB_PERF_CNT_EN is defined; counters wrap.
module arb_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_grant,
    input  logic             d_grant,
    input  logic             wait_cyc,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_wait_cycles
);

    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
    logic [CNT_W-1:0] w_cnt_q, w_cnt_d;

    always_comb begin
        i_cnt_d = i_cnt_q + CNT_W'(i_grant);
        d_cnt_d = d_cnt_q + CNT_W'(d_grant);
        w_cnt_d = w_cnt_q + CNT_W'(wait_cyc);
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
            w_cnt_q <= '0;
        end else begin
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
            w_cnt_q <= w_cnt_d;
        end
    end

    assign perf_i_grants    = i_cnt_q;
    assign perf_d_grants    = d_cnt_q;
    assign perf_wait_cycles = w_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-outstanding mem_* port between fetch and load/store.
// Define ARB_PERF_CNT_EN to add grant and wait-cycle performance counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    input  logic        flush,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_a,
    output logic [31:0] mem_st_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_wait_cycles
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        grant_i, grant_d, starved;

    assign starved = i_req && (starve_q == STARVE_MAX);

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        write_d   = write_q;
        size_d    = size_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_req && !flush && !starved) begin
                    grant_d = 1'b1;
                    state_d = DATA;
                    write_d = d_write;
                    size_d  = d_size;
                    sel_d   = d_sel;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    if (i_req && starve_q != STARVE_MAX)
                        starve_d = starve_q + SW'(1);
                end else if (i_req) begin
                    grant_i  = 1'b1;
                    state_d  = INST;
                    write_d  = 1'b0;
                    size_d   = SZ_WORD;
                    sel_d    = FETCH_SEL;
                    addr_d   = i_addr;
                    starve_d = '0;
                end
            end
            INST: begin
                if (mem_ready) begin
                    i_rdata_d = mem_data;
                    i_ready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DATA: begin
                // completion beats a same-cycle flush
                if (mem_ready) begin
                    d_rdata_d = mem_data;
                    d_ready_d = 1'b1;
                    state_d   = IDLE;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            sel_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            write_q   <= write_d;
            size_q    <= size_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    assign mem_access = (state_q == INST)
                     || (state_q == DATA && (mem_ready || !flush));
    assign mem_write   = write_q;
    assign mem_size    = size_q;
    assign mem_sel     = sel_q;
    assign mem_a       = addr_q;
    assign mem_st_data = wdata_q;
    assign i_ready     = i_ready_q;
    assign i_rdata     = i_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_rdata     = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk              (clk),
        .aresetn          (aresetn),
        .i_grant          (grant_i),
        .d_grant          (grant_d),
        .wait_cyc         (mem_access && !mem_ready),
        .perf_i_grants    (perf_i_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_wait_cycles (perf_wait_cycles)
    );
`else
    logic unused_grants;
    assign unused_grants = grant_i ^ grant_d;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        flush;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_a;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_write     (d_write),
        .d_size      (d_size),
        .d_sel       (d_sel),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .flush       (flush),
        .mem_access  (mem_access),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_sel     (mem_sel),
        .mem_a       (mem_a),
        .mem_st_data (mem_st_data),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_inst;
        aresetn = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_write = 0;
        d_size = 0; d_sel = 0; d_addr = 0; d_wdata = 0;
        flush = 0; mem_ready = 0; mem_data = 0;
        tick(); tick();
        chk("rst_access", mem_access, 0);
        chk("rst_a", mem_a, 0);
        chk("rst_sel", mem_sel, 0);
        chk("rst_iready", i_ready, 0);
        chk("rst_dready", d_ready, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        aresetn = 1'b1;
        tick();

        // lone fetch
        i_req = 1; i_addr = 32'hBFC0_0000;
        tick();
        chk("f_access", mem_access, 1);
        chk("f_a", mem_a, 32'hBFC0_0000);
        chk("f_sel", mem_sel, 4'hF);
        chk("f_write", mem_write, 0);
        chk("f_size", mem_size, 2);
        tick(); tick(); tick();
        chk("f_wait_access", mem_access, 1);
        chk("f_wait_iready", i_ready, 0);
        mem_ready = 1; mem_data = 32'h3C1D_0000;
        tick();
        mem_ready = 0; i_req = 0;
        chk("f_iready", i_ready, 1);
        chk("f_irdata", i_rdata, 32'h3C1D_0000);
        chk("f_idle_access", mem_access, 0);
        tick();
        chk("f_iready_once", i_ready, 0);
        chk("f_irdata_hold", i_rdata, 32'h3C1D_0000);

        // mem_ready while idle is ignored
        mem_ready = 1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_ready = 0;
        chk("idle_rdy_i", i_ready, 0);
        chk("idle_rdy_d", d_ready, 0);
        tick();
        chk("idle_rdy_irdata", i_rdata, 32'h3C1D_0000);
        chk("idle_rdy_drdata", d_rdata, 0);

        // simultaneous requests: data first
        i_req = 1; i_addr = 32'hBFC0_0004;
        d_req = 1; d_write = 1; d_size = 2; d_sel = 4'hF;
        d_addr = 32'h1FAF_0000; d_wdata = 32'h1234_5678;
        tick();
        chk("s_access", mem_access, 1);
        chk("s_a", mem_a, 32'h1FAF_0000);
        chk("s_write", mem_write, 1);
        chk("s_stdata", mem_st_data, 32'h1234_5678);
        chk("s_sel", mem_sel, 4'hF);
        mem_ready = 1; mem_data = 0;
        tick();
        mem_ready = 0; d_req = 0; d_write = 0;
        chk("s_dready", d_ready, 1);
        chk("s_gap_access", mem_access, 0);
        tick();
        chk("s_inst_a", mem_a, 32'hBFC0_0004);
        chk("s_inst_write", mem_write, 0);
        chk("s_inst_sel", mem_sel, 4'hF);
        chk("s_dready_once", d_ready, 0);
        mem_ready = 1; mem_data = 32'h0000_0001;
        tick();
        mem_ready = 0; i_req = 0;
        chk("s_iready", i_ready, 1);
        chk("s_irdata", i_rdata, 32'h0000_0001);
        tick();

        // starvation guard: pattern D D D D I repeating
        i_req = 1; i_addr = 32'hBFC0_0100;
        d_req = 1; d_write = 0; d_size = 2; d_sel = 4'hF;
        d_addr = 32'h0000_1000;
        for (int k = 0; k < 10; k++) begin
            exp_inst = (k % 5) == 4;
            tick();
            chk($sformatf("st_a%0d", k), mem_a,
                exp_inst ? 32'hBFC0_0100 : 32'h0000_1000);
            mem_ready = 1; mem_data = k;
            tick();
            mem_ready = 0;
            chk($sformatf("st_ir%0d", k), i_ready, exp_inst);
            chk($sformatf("st_dr%0d", k), d_ready, !exp_inst);
        end
        i_req = 0; d_req = 0;
        tick();
        chk("st_end_access", mem_access, 0);

        // flush blocks a data grant in idle
        d_req = 1; d_size = 0; d_sel = 4'b0001;
        d_addr = 32'h0000_2000; flush = 1;
        tick();
        chk("fi_access", mem_access, 0);
        flush = 0;
        tick();
        chk("fl_access", mem_access, 1);
        chk("fl_size", mem_size, 0);
        chk("fl_sel", mem_sel, 4'b0001);
        tick();
        flush = 1; d_req = 0;
        #1;
        chk("fl_drop", mem_access, 0);
        chk("fl_dready0", d_ready, 0);
        tick();
        flush = 0;
        #1;
        chk("fl_idle_access", mem_access, 0);
        chk("fl_dready1", d_ready, 0);
        tick();
        chk("fl_dready2", d_ready, 0);

        // flush coincident with completion
        d_req = 1; d_addr = 32'h0000_3000;
        tick();
        chk("fc_access", mem_access, 1);
        d_req = 0; flush = 1; mem_ready = 1; mem_data = 32'hCAFE_BABE;
        #1;
        chk("fc_access_held", mem_access, 1);
        tick();
        flush = 0; mem_ready = 0;
        chk("fc_dready", d_ready, 1);
        chk("fc_drdata", d_rdata, 32'hCAFE_BABE);
        tick();

        // reset mid-fetch
        i_req = 1; i_addr = 32'hBFC0_0200;
        tick();
        chk("r_access", mem_access, 1);
        aresetn = 0; mem_ready = 1; mem_data = 32'h5555_AAAA;
        tick();
        chk("r_access0", mem_access, 0);
        chk("r_a0", mem_a, 0);
        chk("r_sel0", mem_sel, 0);
        chk("r_size0", mem_size, 0);
        chk("r_iready0", i_ready, 0);
        chk("r_irdata0", i_rdata, 0);
        chk("r_drdata0", d_rdata, 0);
        aresetn = 1; i_req = 0; mem_ready = 0;
        tick();
        chk("r_iready1", i_ready, 0);
        chk("r_access1", mem_access, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
